// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with at most one outstanding memory read and a
// small in-order buffer toward decode.
// Optional feature macro: FETCH_MISALIGN_EXC_EN. When defined, a misaligned
// redirect target is delivered to decode as one exception entry and fetching
// halts until the next redirect. When undefined, the target is silently aligned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_exc
);
    localparam int               PTR_W     = $clog2(BUF_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

    // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response discarded.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]       state_r;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      req_addr_r;
    logic             started_r;
    logic             halt_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      buf_instr_r [BUF_DEPTH];
    logic [31:0]      buf_pc_r    [BUF_DEPTH];
    logic             buf_exc_r   [BUF_DEPTH];

    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    logic             misalign_s;
    logic [31:0]      target_pc_s;

`ifdef FETCH_MISALIGN_EXC_EN
    // Redirect target taken as-is; a misaligned target becomes an exception entry.
    always_comb begin
        misalign_s  = 1'b0;
        target_pc_s = redirect_pc;
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_s = 1'b1;
        end else begin
            misalign_s = 1'b0;
        end
    end
`else
    // Redirect target forced to word alignment; no exception path exists.
    always_comb begin
        misalign_s  = 1'b0;
        target_pc_s = redirect_pc & 32'hFFFF_FFFC;
    end
`endif

    // Request, push and pop qualifiers; a redirect overrides all three.
    always_comb begin
        issue_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (started_r && (state_r == ST_IDLE) && (count_r < DEPTH_C) && !redirect && !halt_r) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if ((state_r == ST_WAIT) && mem_rvalid && !redirect) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if ((count_r != CNT_ZERO) && if_ready && !redirect) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign mem_req  = issue_s;
    assign mem_addr = fetch_pc_r;
    assign if_valid = (count_r != CNT_ZERO);
    assign if_instr = buf_instr_r[rd_ptr_r];
    assign if_pc    = buf_pc_r[rd_ptr_r];
    assign if_exc   = buf_exc_r[rd_ptr_r];

    // Fetch state machine, fetch address and buffer bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_addr_r <= 32'h0000_0000;
            started_r  <= 1'b0;
            halt_r     <= 1'b0;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
        end else begin
            // started_r keeps the first request off until reset_n has been seen high.
            started_r <= 1'b1;
            if (redirect) begin
                fetch_pc_r <= target_pc_s;
                rd_ptr_r   <= PTR_ZERO;
                halt_r     <= misalign_s;
                wr_ptr_r   <= misalign_s ? PTR_ONE : PTR_ZERO;
                count_r    <= misalign_s ? CNT_ONE : CNT_ZERO;
                // An in-flight request whose data is not here yet must be swallowed later.
                if ((state_r != ST_IDLE) && !mem_rvalid) begin
                    state_r <= ST_DROP;
                end else begin
                    state_r <= ST_IDLE;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (issue_s) begin
                            state_r    <= ST_WAIT;
                            req_addr_r <= fetch_pc_r;
                            fetch_pc_r <= fetch_pc_r + 32'd4;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_rvalid) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (mem_rvalid) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Buffer storage: cleared on reset so decode sees zeros, then written on push.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_r[i] <= 32'h0000_0000;
                buf_pc_r[i]    <= 32'h0000_0000;
                buf_exc_r[i]   <= 1'b0;
            end
        end else if (misalign_s) begin
            buf_instr_r[PTR_ZERO] <= NOP_INSTR;
            buf_pc_r[PTR_ZERO]    <= redirect_pc;
            buf_exc_r[PTR_ZERO]   <= 1'b1;
        end else if (push_s) begin
            buf_instr_r[wr_ptr_r] <= mem_rdata;
            buf_pc_r[wr_ptr_r]    <= req_addr_r;
            buf_exc_r[wr_ptr_r]   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit against a
// transaction-level model (queue of expected decode entries, expected fetch
// address, outstanding-request flag). Honors FETCH_MISALIGN_EXC_EN.
module tb_fetch_unit;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int          TB_DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_exc;

    fetch_unit #(.RESET_PC(TB_RESET_PC), .BUF_DEPTH(TB_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .if_exc(if_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;

    int          vectors = 0;
    int          miscompares = 0;
    // Reference model
    ent_t        q[$];
    ent_t        e;
    logic [31:0] fpc;
    logic [31:0] req_addr;
    bit          outstanding = 1'b0;
    bit          keep = 1'b0;
    bit          started = 1'b0;
    bit          halted = 1'b0;
    bit          known = 1'b0;
    bit          exp_req;
    bit          do_pop;
    // Memory environment
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          fixed_lat = 1;
    // Observations from the latest step
    logic        obs_req, obs_valid, obs_exc, obs_pop;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ (a << 3);
    endfunction

    // One clock cycle: drive memory, check DUT against model, advance model.
    task automatic step();
        mem_rvalid = (pend_cnt == 1);
        mem_rdata  = mem_rvalid ? memfn(pend_addr) : $urandom();
        @(negedge clk);
        obs_req = mem_req; obs_addr = mem_addr; obs_valid = if_valid;
        obs_pc = if_pc; obs_instr = if_instr; obs_exc = if_exc;
        obs_pop = if_valid & if_ready;
        exp_req = started && !outstanding && (q.size() < TB_DEPTH) && !redirect && !halted;
        if (known) begin
            vectors++;
            if (mem_req !== exp_req) begin
                miscompares++;
                $display("FAIL mem_req: got %b expected %b at %0t", mem_req, exp_req, $time);
            end
            vectors++;
            if (mem_addr !== fpc) begin
                miscompares++;
                $display("FAIL mem_addr: got %h expected %h at %0t", mem_addr, fpc, $time);
            end
            vectors++;
            if (if_valid !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL if_valid: got %b expected %b at %0t", if_valid, (q.size() != 0), $time);
            end
            if (q.size() != 0) begin
                vectors++;
                if ({if_pc, if_instr, if_exc} !== {q[0].pc, q[0].instr, q[0].exc}) begin
                    miscompares++;
                    $display("FAIL head_entry: got pc=%h instr=%h exc=%b expected pc=%h instr=%h exc=%b at %0t",
                             if_pc, if_instr, if_exc, q[0].pc, q[0].instr, q[0].exc, $time);
                end
            end
        end
        if (!reset_n) begin
            q.delete(); fpc = TB_RESET_PC; outstanding = 0; keep = 0;
            started = 0; halted = 0; known = 1;
        end else if (known) begin
            do_pop  = (q.size() != 0) && if_ready;
            started = 1;
            if (redirect) begin
                q.delete();
                if (outstanding && mem_rvalid) outstanding = 0;
                keep = 0; halted = 0;
`ifdef FETCH_MISALIGN_EXC_EN
                fpc = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) begin
                    e.pc = redirect_pc; e.instr = 32'h0000_0013; e.exc = 1'b1;
                    q.push_back(e); halted = 1;
                end
`else
                fpc = redirect_pc & 32'hFFFF_FFFC;
`endif
            end else begin
                if (do_pop) void'(q.pop_front());
                if (outstanding && mem_rvalid) begin
                    if (keep) begin
                        e.pc = req_addr; e.instr = mem_rdata; e.exc = 1'b0;
                        q.push_back(e);
                    end
                    outstanding = 0;
                end
                if (exp_req) begin
                    outstanding = 1; keep = 1; req_addr = fpc; fpc = fpc + 32'd4;
                end
            end
        end
        if (pend_cnt > 0) pend_cnt--;
        if (mem_req === 1'b1) begin
            pend_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
            pend_addr = mem_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; redirect = 1'b0;
        step(); step();
        reset_n = 1'b1;
    endtask

    task automatic wait_pop(input string name, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (obs_pop === 1'b1) found = 1;
        end
        if (!found) begin
            miscompares++;
            $display("FAIL %s: no pop within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_req_addr(input string name, input logic [31:0] addr, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (obs_req === 1'b1 && obs_addr === addr) found = 1;
        end
        if (!found) begin
            miscompares++;
            $display("FAIL %s: no request to %h within %0d cycles", name, addr, budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = $urandom(); if_ready = 1'b1;
        repeat (3) step();
        vectors++; if (obs_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", obs_req); end
        vectors++; if (obs_addr !== TB_RESET_PC) begin miscompares++; $display("FAIL rst_addr: got %h expected %h", obs_addr, TB_RESET_PC); end
        vectors++; if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", obs_valid); end
        vectors++; if (obs_instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h expected 0", obs_instr); end
        vectors++; if (obs_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h expected 0", obs_pc); end
        vectors++; if (obs_exc !== 1'b0) begin miscompares++; $display("FAIL rst_exc: got %b expected 0", obs_exc); end
        reset_n = 1'b1;
        step();
        vectors++; if (obs_req !== 1'b0) begin miscompares++; $display("FAIL req_before_seen_high: got %b expected 0", obs_req); end
        step();
        vectors++;
        if (obs_req !== 1'b1 || obs_addr !== TB_RESET_PC) begin
            miscompares++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", obs_req, obs_addr, TB_RESET_PC);
        end
    endtask

    task automatic test_stream();
        int          req_t[$];
        logic [31:0] req_a[$];
        logic [31:0] pops[$];
        do_reset(); if_ready = 1'b1; fixed_lat = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (obs_req === 1'b1) begin req_t.push_back(i); req_a.push_back(obs_addr); end
            if (obs_pop === 1'b1) pops.push_back(obs_pc);
        end
        vectors++;
        if (req_a.size() < 4) begin
            miscompares++; $display("FAIL stream_reqs: got %0d requests expected at least 4", req_a.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (req_a[k] !== 32'(4 * k)) begin miscompares++; $display("FAIL stream_addr: got %h expected %h", req_a[k], 32'(4 * k)); end
                vectors++;
                if (req_t[k+1] - req_t[k] != 2) begin miscompares++; $display("FAIL stream_gap: got %0d expected 2", req_t[k+1] - req_t[k]); end
            end
        end
        vectors++;
        if (pops.size() < 3) begin
            miscompares++; $display("FAIL stream_pops: got %0d expected at least 3", pops.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (pops[k] !== 32'(4 * k)) begin miscompares++; $display("FAIL stream_pc: got %h expected %h", pops[k], 32'(4 * k)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset(); if_ready = 1'b0; fixed_lat = 1;
        repeat (10) begin step(); if (obs_req === 1'b1) n++; end
        vectors++; if (n != 2) begin miscompares++; $display("FAIL bp_reqs: got %0d expected 2", n); end
        vectors++;
        if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
            miscompares++; $display("FAIL bp_full: got valid=%b req=%b expected valid=1 req=0", obs_valid, obs_req);
        end
        if_ready = 1'b1; step(); if_ready = 1'b0;
        vectors++; if (obs_pop !== 1'b1) begin miscompares++; $display("FAIL bp_pop: got %b expected 1", obs_pop); end
        n = 0;
        repeat (4) begin step(); if (obs_req === 1'b1) n++; end
        vectors++; if (n != 1) begin miscompares++; $display("FAIL bp_refill: got %0d requests expected 1", n); end
    endtask

    task automatic test_redirect_drop();
        do_reset(); if_ready = 1'b1; fixed_lat = 3;
        wait_req_addr("drop_wait8", 32'h8, 40);
        redirect = 1'b1; redirect_pc = 32'h100; step(); redirect = 1'b0;
        step();
        vectors++; if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL drop_flush: got %b expected 0", obs_valid); end
        wait_pop("drop_pop", 20);
        vectors++; if (obs_pc !== 32'h100) begin miscompares++; $display("FAIL drop_pc: got %h expected 00000100", obs_pc); end
    endtask

    task automatic test_redirect_collide();
        int          n = 0;
        logic [31:0] tgt;
        do_reset(); if_ready = 1'b0; fixed_lat = 1;
        for (int i = 0; i < 20 && n < 2; i++) begin step(); if (obs_req === 1'b1) n++; end
        vectors++; if (n != 2) begin miscompares++; $display("FAIL col_setup: got %0d requests expected 2", n); end
        tgt = $urandom() & 32'hFFFF_FFFC;
        redirect = 1'b1; redirect_pc = tgt; if_ready = 1'b1;
        step();
        redirect = 1'b0; if_ready = 1'b0;
        vectors++; if (obs_valid !== 1'b1) begin miscompares++; $display("FAIL col_pre_valid: got %b expected 1", obs_valid); end
        step();
        vectors++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== tgt) begin
            miscompares++; $display("FAIL col_after: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=%h", obs_valid, obs_req, obs_addr, tgt);
        end
    endtask

    task automatic test_misalign();
        int n = 0;
        do_reset(); if_ready = 1'b1; fixed_lat = 1;
        repeat (6) step();
        redirect = 1'b1; redirect_pc = 32'h102; step(); redirect = 1'b0; if_ready = 1'b0;
        step();
`ifdef FETCH_MISALIGN_EXC_EN
        vectors++;
        if (obs_valid !== 1'b1 || obs_exc !== 1'b1 || obs_pc !== 32'h102 || obs_instr !== 32'h13 || obs_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_entry: got valid=%b exc=%b pc=%h instr=%h req=%b expected 1 1 00000102 00000013 0",
                     obs_valid, obs_exc, obs_pc, obs_instr, obs_req);
        end
        if_ready = 1'b1;
        repeat (6) begin step(); if (obs_req === 1'b1) n++; end
        vectors++; if (n != 0) begin miscompares++; $display("FAIL mis_halt: got %0d requests expected 0", n); end
`else
        vectors++;
        if (obs_addr !== 32'h100 || obs_exc !== 1'b0) begin
            miscompares++; $display("FAIL mis_align: got addr=%h exc=%b expected addr=00000100 exc=0", obs_addr, obs_exc);
        end
        if_ready = 1'b1;
        wait_pop("mis_pop", 20);
        vectors++;
        if (obs_pc !== 32'h100 || obs_exc !== 1'b0) begin
            miscompares++; $display("FAIL mis_pc: got pc=%h exc=%b expected pc=00000100 exc=0", obs_pc, obs_exc);
        end
        n = 0;
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] pops[$];
        logic [31:0] want[3];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        do_reset(); if_ready = 1'b1; fixed_lat = 1;
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; step(); redirect = 1'b0;
        for (int i = 0; i < 30 && pops.size() < 3; i++) begin
            step();
            if (obs_pop === 1'b1) pops.push_back(obs_pc);
        end
        vectors++;
        if (pops.size() < 3) begin
            miscompares++; $display("FAIL wrap_pops: got %0d expected 3", pops.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (pops[k] !== want[k]) begin miscompares++; $display("FAIL wrap_pc: got %h expected %h", pops[k], want[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); if_ready = 1'b1; fixed_lat = 2;
        wait_req_addr("rmid_wait8", 32'h8, 40);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        step();
        vectors++;
        if (obs_valid !== 1'b0 || obs_instr !== 32'h0 || obs_pc !== 32'h0 || obs_exc !== 1'b0) begin
            miscompares++; $display("FAIL rmid_clear: got valid=%b instr=%h pc=%h exc=%b expected all zero", obs_valid, obs_instr, obs_pc, obs_exc);
        end
        wait_pop("rmid_pop", 20);
        vectors++;
        if (obs_pc !== TB_RESET_PC || obs_instr !== memfn(TB_RESET_PC)) begin
            miscompares++; $display("FAIL rmid_first: got pc=%h instr=%h expected pc=%h instr=%h", obs_pc, obs_instr, TB_RESET_PC, memfn(TB_RESET_PC));
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset(); fixed_lat = 0;
        for (int i = 0; i < 1500; i++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 19) == 0);
            r = $urandom();
            case ($urandom_range(0, 3))
                0:       redirect_pc = r;
                1:       redirect_pc = 32'hFFFF_FFF0 | (r & 32'h0000_000C);
                default: redirect_pc = r & 32'hFFFF_FFFC;
            endcase
            step();
        end
        redirect = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mem_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-006 SHALL have port mem_addr  output  32  word-aligned read address, valid with mem_req.
REQ-007 SHALL have port mem_rvalid  input  1  read data valid, at least 1 cycle after mem_req.
REQ-008 SHALL have port mem_rdata  input  32  read data, valid with mem_rvalid.
REQ-009 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  32  new fetch address, valid with redirect.
REQ-011 SHALL have port if_valid  output  1  buffer head valid, toward decode.
REQ-012 SHALL have port if_ready  input  1  decode accepts head this cycle.
REQ-013 SHALL have port if_instr  output  32  head instruction word.
REQ-014 SHALL have port if_pc  output  32  head instruction address.
REQ-015 SHALL have port if_exc  output  1  head carries misaligned-fetch exception.

Function
REQ-016 SHALL implement states IDLE (no request outstanding), WAIT (one request outstanding, response kept), DROP (one request outstanding, response discarded).
REQ-017 SHALL issue mem_req in IDLE only when buffer occupancy is below BUF_DEPTH and redirect is low; then go to WAIT and increment fetch_pc by 4.
REQ-018 SHALL allow at most one outstanding request; no mem_req in WAIT or DROP.
REQ-019 On mem_rvalid in WAIT, SHALL push {mem_rdata, request address, 0} into the buffer and return to IDLE; the entry is visible on if_valid the next cycle.
REQ-020 On mem_rvalid in DROP, SHALL discard the data and return to IDLE.
REQ-021 SHALL pop the head when if_valid and if_ready are both high; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-022 On redirect, SHALL flush the buffer (if_valid low next cycle), set fetch_pc to redirect_pc, and go to DROP if a request is outstanding and its data does not arrive this cycle, else to IDLE.
REQ-023 Redirect SHALL override a simultaneous mem_rvalid push and if_ready pop; data arriving that cycle is discarded.
REQ-024 fetch_pc and buffer pointers SHALL wrap modulo 2^32 and modulo BUF_DEPTH respectively; 32'hFFFF_FFFC+4 gives 0.
REQ-025 Best-case throughput SHALL be one instruction per 2 cycles with 1-cycle memory latency.

Reset
REQ-026 While reset_n is low at a clock edge: state IDLE, fetch_pc RESET_PC, buffer empty, mem_req 0, mem_addr RESET_PC, if_valid 0, if_instr 0, if_pc 0, if_exc 0.
REQ-027 Reset mid-request SHALL abandon the request; a mem_rvalid arriving during reset, or in the first cycle after reset before any new mem_req, SHALL be ignored.
REQ-028 First mem_req SHALL assert in the first cycle after reset_n is seen high.

Configuration
REQ-029 Macro FETCH_MISALIGN_EXC_EN SHALL control misaligned-redirect handling.
REQ-030 With FETCH_MISALIGN_EXC_EN defined, redirect_pc[1:0]!=0 SHALL push one entry {32'h0000_0013, redirect_pc, if_exc=1} without a memory request and then halt fetching until the next redirect.
REQ-031 Without FETCH_MISALIGN_EXC_EN, redirect_pc[1:0] SHALL be forced to 0, if_exc SHALL stay 0, and fetching SHALL continue from the aligned address.

Verification
REQ-032 Reset with RESET_PC=0, memory latency 1, if_ready=1 -> mem_addr 0,4,8 every 2 cycles; if_pc 0,4,8 with matching if_instr.
REQ-033 if_ready=0 for 10 cycles -> exactly 2 requests issued, occupancy 2, no further mem_req; one if_ready=1 cycle -> exactly one pop then one new request.
REQ-034 Redirect to 32'h100 while a request to 8 is outstanding -> response for 8 dropped, next if_pc 32'h100, buffer empty the cycle after redirect.
REQ-035 Redirect coinciding with mem_rvalid and if_ready -> no push, no pop visible; next mem_addr equals redirect_pc.
REQ-036 Redirect to 32'h102: macro defined -> if_exc=1, if_pc 32'h102, no mem_req; macro undefined -> mem_addr 32'h100, if_exc 0.
REQ-037 reset_n low for 1 cycle during WAIT, mem_rvalid one cycle later -> data ignored, first if_pc equals RESET_PC.
